// File: rtl/fa_vector_scanner_if.sv
// Signal bundle between the full-adder vector scanner and its environment:
// scan control/status plus the stimulus/response wires of the adder under test.
interface fa_vector_scanner_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             dut_a;
  logic             dut_b;
  logic             dut_cin;
  logic             dut_sum;
  logic             dut_cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [7:0]       fail_mask;
  logic [2:0]       first_fail_vec;
  logic             first_fail_valid;

  // Scanner side
  modport master (
    input  start, dut_sum, dut_cout,
    output dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, fail_mask, first_fail_vec, first_fail_valid
  );

  // Environment side: requester plus the adder under test
  modport slave (
    output start, dut_sum, dut_cout,
    input  dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, fail_mask, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/fa_vector_scanner.sv
// Exhaustive full-adder checker: walks all 8 {a,b,cin} vectors into the adder,
// holds each for SETTLE cycles, samples sum/carry in a CHECK cycle and records
// mismatches against a golden full adder (fail mask, saturating count, first
// failing vector, pass flag).
module fa_vector_scanner #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 4
) (
  input logic               clk,
  input logic               rst_n,
  fa_vector_scanner_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           r_state;
  logic [2:0]       r_vec;
  logic [3:0]       r_settle_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_count;
  logic [7:0]       r_fail_mask;
  logic [2:0]       r_first_vec;
  logic             r_first_valid;

  logic w_exp_sum;
  logic w_exp_cout;
  logic w_mismatch;
  logic w_err_sat;

  // Golden full adder on the vector currently driven, and the mismatch flag
  assign w_exp_sum  = r_vec[2] ^ r_vec[1] ^ r_vec[0];
  assign w_exp_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_mismatch = (bus.dut_sum != w_exp_sum) || (bus.dut_cout != w_exp_cout);
  assign w_err_sat  = &r_err_count;

  // Vector index doubles as the registered adder stimulus (a is the MSB);
  // it is held at 0 outside a scan.
  assign bus.dut_a            = r_vec[2];
  assign bus.dut_b            = r_vec[1];
  assign bus.dut_cin          = r_vec[0];
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_count        = r_err_count;
  assign bus.fail_mask        = r_fail_mask;
  assign bus.first_fail_vec   = r_first_vec;
  assign bus.first_fail_valid = r_first_valid;

  // Scan FSM with registered stimulus, status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vec         <= 3'd0;
      r_settle_cnt  <= 4'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_count   <= '0;
      r_fail_mask   <= 8'h00;
      r_first_vec   <= 3'd0;
      r_first_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_pass        <= 1'b0;
            r_err_count   <= '0;
            r_fail_mask   <= 8'h00;
            r_first_vec   <= 3'd0;
            r_first_valid <= 1'b0;
            r_vec         <= 3'd0;
            r_settle_cnt  <= 4'd0;
            r_busy        <= 1'b1;
            r_state       <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_fail_mask[r_vec] <= 1'b1;
            if (!w_err_sat) begin
              r_err_count <= r_err_count + ERR_W'(1);
            end
            if (!r_first_valid) begin
              r_first_vec   <= r_vec;
              r_first_valid <= 1'b1;
            end
          end
          if (r_vec == 3'd7) begin
            // Last vector: the final compare is folded into pass here
            r_pass  <= (r_err_count == '0) && !w_mismatch;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_vec   <= 3'd0;
            r_state <= S_DONE;
          end else begin
            r_vec        <= r_vec + 3'd1;
            r_settle_cnt <= 4'd0;
            r_state      <= S_APPLY;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
